// File: rtl/dbn_pkg.sv
// dbn_pkg
// Shared definitions for the DBN layer sequencer slice:
//   - default operand / accumulator widths and layer size limits
//   - FSM state encoding for dbn_layer_sequencer
//   - signed saturation bounds for the WIDTH_OUT accumulator
// No ports (package). Optional feature macro used by importers: DBN_ACC_SAT_EN.

package dbn_pkg;

    localparam int DEF_WIDTH_IN  = 16;
    localparam int DEF_WIDTH_OUT = 32;
    localparam int DEF_N_IN_MAX  = 784;
    localparam int DEF_N_OUT_MAX = 500;
    localparam int DEF_MULT_LAT  = 2;
    localparam int DEF_XA_W      = 10;
    localparam int DEF_WA_W      = 19;
    localparam int DEF_YA_W      = 9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [DEF_WIDTH_OUT-1:0] SAT_MAX = {1'b0, {(DEF_WIDTH_OUT-1){1'b1}}};
    localparam logic [DEF_WIDTH_OUT-1:0] SAT_MIN = {1'b1, {(DEF_WIDTH_OUT-1){1'b0}}};

endpackage

// File: rtl/dbn_acc.sv
// dbn_acc
// Load/accumulate register for one neuron's dot product.
//   clk   in   clock
//   rst   in   synchronous active-low reset
//   clear in   zero acc and ovf (used right after a neuron is written out)
//   en    in   a product is arriving this cycle
//   load  in   with en: this is the neuron's first product, load instead of add
//   din   in   W  product from the multiplier, taken as-is
//   acc   out  W  running sum
//   ovf   out  1  sum saturated at some step (only with DBN_ACC_SAT_EN)
// Macro DBN_ACC_SAT_EN: signed saturation to max/min on overflow and a sticky
// ovf flag. Without it the sum wraps modulo 2^W and ovf stays 0.

module dbn_acc
    import dbn_pkg::*;
#(
    parameter int W = DEF_WIDTH_OUT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] din,
    output logic [W-1:0] acc,
    output logic         ovf
);

    localparam logic [W-1:0] SAT_HI = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_LO = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0] sum;
    logic         sat_hi;
    logic         sat_lo;

    // Raw wrapping sum; overflow is detected from operand/result signs.
    always_comb begin
        sum    = acc + din;
        sat_hi = 1'b0;
        sat_lo = 1'b0;
`ifdef DBN_ACC_SAT_EN
        sat_hi = !acc[W-1] && !din[W-1] &&  sum[W-1];
        sat_lo =  acc[W-1] &&  din[W-1] && !sum[W-1];
`endif
    end

    // The first product loads acc directly, so no clear cycle is needed
    // between neurons; clear exists so n_in==0 layers write zeros.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (clear) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (en) begin
            if (load) begin
                acc <= din;
                ovf <= 1'b0;
            end else if (sat_hi) begin
                acc <= SAT_HI;
                ovf <= 1'b1;
            end else if (sat_lo) begin
                acc <= SAT_LO;
                ovf <= 1'b1;
            end else begin
                acc <= sum;
            end
        end
    end

endmodule

// File: rtl/dbn_layer_sequencer.sv
// dbn_layer_sequencer
// Sequences one fully-connected DBN layer on a shared signed multiplier:
// for each neuron j it streams x[i] and w[j*n_in+i], accumulates the
// products and writes y[j] to the next level's input memory.
//   clk, rst          clock, synchronous active-low reset
//   start             launch a layer (only sampled in IDLE)
//   cfg_n_in/n_out    layer size, latched with start, clamped to *_MAX
//   busy, done        state != IDLE, one-cycle end-of-layer pulse
//   mem_rd, x_addr, w_addr, x_data, w_data   x/w memory port (1-cycle read)
//   mul_vld, mul_a, mul_b, mul_res           multiplier port (MULT_LAT)
//   y_we, y_addr, y_data, y_ovf              output memory write port
// Macro DBN_ACC_SAT_EN (in dbn_acc): saturating accumulation, y_ovf flag.

module dbn_layer_sequencer
    import dbn_pkg::*;
#(
    parameter int WIDTH_IN  = DEF_WIDTH_IN,
    parameter int WIDTH_OUT = DEF_WIDTH_OUT,
    parameter int N_IN_MAX  = DEF_N_IN_MAX,
    parameter int N_OUT_MAX = DEF_N_OUT_MAX,
    parameter int MULT_LAT  = DEF_MULT_LAT,
    parameter int XA_W      = DEF_XA_W,
    parameter int WA_W      = DEF_WA_W,
    parameter int YA_W      = DEF_YA_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [XA_W-1:0]      cfg_n_in,
    input  logic [YA_W-1:0]      cfg_n_out,
    output logic                 busy,
    output logic                 done,
    output logic                 mem_rd,
    output logic [XA_W-1:0]      x_addr,
    output logic [WA_W-1:0]      w_addr,
    input  logic [WIDTH_IN-1:0]  x_data,
    input  logic [WIDTH_IN-1:0]  w_data,
    output logic                 mul_vld,
    output logic [WIDTH_IN-1:0]  mul_a,
    output logic [WIDTH_IN-1:0]  mul_b,
    input  logic [WIDTH_OUT-1:0] mul_res,
    output logic                 y_we,
    output logic [YA_W-1:0]      y_addr,
    output logic [WIDTH_OUT-1:0] y_data,
    output logic                 y_ovf
);

    localparam logic [XA_W-1:0] N_IN_LIM  = XA_W'(N_IN_MAX);
    localparam logic [YA_W-1:0] N_OUT_LIM = YA_W'(N_OUT_MAX);

    state_t state;
    state_t state_nxt;

    logic [XA_W-1:0]      n_in;
    logic [YA_W-1:0]      n_out;
    logic [XA_W-1:0]      i_cnt;
    logic [YA_W-1:0]      j_cnt;
    logic [WA_W-1:0]      wbase;
    logic [MULT_LAT:0]    vld_pipe;
    logic [MULT_LAT:0]    first_pipe;
    logic [MULT_LAT:0]    last_pipe;
    logic [XA_W-1:0]      cfg_n_in_c;
    logic [YA_W-1:0]      cfg_n_out_c;
    logic                 fetch;
    logic                 write;
    logic                 last_issue;
    logic                 last_neuron;
    logic [WIDTH_OUT-1:0] acc;
    logic                 acc_ovf;

    assign cfg_n_in_c  = (cfg_n_in  > N_IN_LIM)  ? N_IN_LIM  : cfg_n_in;
    assign cfg_n_out_c = (cfg_n_out > N_OUT_LIM) ? N_OUT_LIM : cfg_n_out;

    assign fetch       = (state == ST_FETCH);
    assign write       = (state == ST_WRITE);
    assign last_issue  = (i_cnt == n_in - XA_W'(1));
    assign last_neuron = (j_cnt == n_out - YA_W'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // DRAIN ends when the 'last' tag reaches the result stage, which is
    // exactly MULT_LAT+1 cycles after the last issue.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_n_out == '0) begin
                        state_nxt = ST_DONE;
                    end else if (cfg_n_in == '0) begin
                        state_nxt = ST_WRITE;
                    end else begin
                        state_nxt = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                if (last_issue) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (last_pipe[MULT_LAT]) begin
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (last_neuron) begin
                    state_nxt = ST_DONE;
                end else if (n_in == '0) begin
                    state_nxt = ST_WRITE;
                end else begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Config latch, address counters and issue-tag pipeline. The weight base
    // advances by n_in per neuron so no multiplier is needed for w_addr.
    always_ff @(posedge clk) begin
        if (!rst) begin
            n_in       <= '0;
            n_out      <= '0;
            i_cnt      <= '0;
            j_cnt      <= '0;
            wbase      <= '0;
            vld_pipe   <= '0;
            first_pipe <= '0;
            last_pipe  <= '0;
        end else begin
            vld_pipe   <= {vld_pipe[MULT_LAT-1:0],   fetch};
            first_pipe <= {first_pipe[MULT_LAT-1:0], fetch && (i_cnt == '0)};
            last_pipe  <= {last_pipe[MULT_LAT-1:0],  fetch && last_issue};
            case (state)
                ST_IDLE: begin
                    i_cnt <= '0;
                    j_cnt <= '0;
                    wbase <= '0;
                    if (start) begin
                        n_in  <= cfg_n_in_c;
                        n_out <= cfg_n_out_c;
                    end
                end
                ST_FETCH: begin
                    i_cnt <= last_issue ? '0 : i_cnt + XA_W'(1);
                end
                ST_WRITE: begin
                    if (!last_neuron) begin
                        j_cnt <= j_cnt + YA_W'(1);
                        wbase <= wbase + WA_W'(n_in);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    dbn_acc #(
        .W(WIDTH_OUT)
    ) u_acc (
        .clk  (clk),
        .rst  (rst),
        .clear(write),
        .en   (vld_pipe[MULT_LAT]),
        .load (first_pipe[MULT_LAT]),
        .din  (mul_res),
        .acc  (acc),
        .ovf  (acc_ovf)
    );

    // Outputs are decoded from state so they are all zero while idle.
    always_comb begin
        busy    = (state != ST_IDLE);
        done    = (state == ST_DONE);
        mem_rd  = fetch;
        x_addr  = fetch ? i_cnt : '0;
        w_addr  = fetch ? (wbase + WA_W'(i_cnt)) : '0;
        mul_vld = vld_pipe[0];
        mul_a   = vld_pipe[0] ? x_data : '0;
        mul_b   = vld_pipe[0] ? w_data : '0;
        y_we    = write;
        y_addr  = write ? j_cnt : '0;
        y_data  = write ? acc : '0;
        y_ovf   = write && acc_ovf;
    end

endmodule

// File: tb/tb_dbn_layer_sequencer.sv
// tb_dbn_layer_sequencer
// Self-checking bench for dbn_layer_sequencer. Models the x/w memories
// (1-cycle read), a 2-cycle multiplier returning a*b<<1, and computes each
// neuron's expected sum and timing directly from the layer definition.
// Honours DBN_ACC_SAT_EN for the expected accumulation behaviour.

module tb_dbn_layer_sequencer;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  cfg_n_in = '0;
    logic [8:0]  cfg_n_out = '0;
    logic        busy, done, mem_rd, mul_vld, y_we, y_ovf;
    logic [9:0]  x_addr;
    logic [18:0] w_addr;
    logic [15:0] x_data = '0;
    logic [15:0] w_data = '0;
    logic [15:0] mul_a, mul_b;
    logic [31:0] mul_res;
    logic [8:0]  y_addr;
    logic [31:0] y_data;

    logic [15:0] x_mem [0:1023];
    logic [15:0] w_mem [0:524287];
    logic [31:0] m1 = '0;
    logic [31:0] m2 = '0;
    bit          force_res = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dbn_layer_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cfg_n_in (cfg_n_in),
        .cfg_n_out(cfg_n_out),
        .busy     (busy),
        .done     (done),
        .mem_rd   (mem_rd),
        .x_addr   (x_addr),
        .w_addr   (w_addr),
        .x_data   (x_data),
        .w_data   (w_data),
        .mul_vld  (mul_vld),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_res  (mul_res),
        .y_we     (y_we),
        .y_addr   (y_addr),
        .y_data   (y_data),
        .y_ovf    (y_ovf)
    );

    // Memories with one cycle of read latency, and a two-stage multiplier.
    always @(posedge clk) begin
        if (mem_rd) begin
            x_data <= x_mem[x_addr];
            w_data <= w_mem[w_addr];
        end
        m1 <= mul_vld ? ((32'($signed(mul_a)) * 32'($signed(mul_b))) << 1) : 32'h0;
        m2 <= m1;
    end

    assign mul_res = force_res ? 32'h4000_0000 : m2;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fillMemory(input bit randomFill);
        for (int k = 0; k < 1024; k++) begin
            x_mem[k] = randomFill ? 16'($urandom) : 16'h4000;
        end
        for (int k = 0; k < 4096; k++) begin
            w_mem[k] = randomFill ? 16'($urandom) : 16'h2000;
        end
    endtask

    // Expected y for neuron j: sum over i of the 32-bit product x[i]*w*2,
    // either wrapped to 32 bits or clamped to the signed 32-bit range.
    function automatic logic [32:0] refNeuron(input int nIn, input int j, input bit forced);
        longint      acc;
        longint      p;
        longint      prod;
        logic [31:0] t;
        bit          ovf;
        acc = 0;
        ovf = 1'b0;
        for (int i = 0; i < nIn; i++) begin
            if (forced) begin
                p = 64'sh4000_0000;
            end else begin
                prod = longint'($signed(x_mem[i])) * longint'($signed(w_mem[j * nIn + i])) * 2;
                t    = prod[31:0];
                p    = longint'($signed(t));
            end
            acc = acc + p;
`ifdef DBN_ACC_SAT_EN
            if (acc > SMAX) begin
                acc = SMAX;
                ovf = 1'b1;
            end else if (acc < SMIN) begin
                acc = SMIN;
                ovf = 1'b1;
            end
`else
            acc = longint'($signed(acc[31:0]));
`endif
        end
        return {ovf, acc[31:0]};
    endfunction

    // Runs one layer: start at relative cycle 0, optional second start plus
    // cfg change at perturbAt, optional rst low at resetAt. Outputs are
    // sampled on the falling edge of every cycle.
    task automatic applyStimulus(input int cfgIn, input int cfgOut, input int perturbAt,
                                 input int resetAt, output int lastW,
                                 output logic [31:0] firstY, output logic firstOvf);
        int          nIn, nOut, per, doneAt, runLen;
        int          writes, dones, doneCyc, rdCnt, vldCnt;
        int          addrErrs, opErrs, busyErrs;
        bit          expBusy;
        logic [32:0] yRef;
        nIn      = (cfgIn  > 784) ? 784 : cfgIn;
        nOut     = (cfgOut > 500) ? 500 : cfgOut;
        per      = (nIn == 0) ? 1 : nIn + 4;
        doneAt   = nOut * per + 1;
        runLen   = (resetAt >= 0) ? 40 : doneAt + 6;
        writes   = 0;
        dones    = 0;
        doneCyc  = -1;
        rdCnt    = 0;
        vldCnt   = 0;
        addrErrs = 0;
        opErrs   = 0;
        busyErrs = 0;
        lastW    = -1;
        firstY   = 'x;
        firstOvf = 1'bx;
        @(negedge clk);
        cfg_n_in  = 10'(cfgIn);
        cfg_n_out = 9'(cfgOut);
        for (int r = 0; r < runLen; r++) begin
            start = (r == 0) || (r == perturbAt);
            if (r == perturbAt) begin
                cfg_n_in  = 10'd7;
                cfg_n_out = 9'd5;
            end
            rst = (r == resetAt) ? 1'b0 : 1'b1;

            expBusy = (r >= 1) && (r <= doneAt) && !((resetAt >= 0) && (r > resetAt));
            if (busy !== expBusy) busyErrs++;

            if (mem_rd === 1'b1) begin
                if (nIn == 0 || w_addr !== 19'(rdCnt) || x_addr !== 10'(rdCnt % nIn)) addrErrs++;
                lastW = int'(w_addr);
                rdCnt++;
            end

            if (mul_vld === 1'b1) begin
                if (nIn == 0 || mul_a !== x_mem[vldCnt % nIn] || mul_b !== w_mem[vldCnt]) opErrs++;
                vldCnt++;
            end else if (mul_a !== 16'h0 || mul_b !== 16'h0) begin
                opErrs++;
            end

            if (y_we === 1'b1) begin
                yRef = refNeuron(nIn, writes, force_res);
                checkOutput("y_cycle", r, (writes + 1) * per);
                checkOutput("y_addr", y_addr, writes);
                checkOutput("y_data", y_data, yRef[31:0]);
                checkOutput("y_ovf", y_ovf, yRef[32]);
                if (writes == 0) begin
                    firstY   = y_data;
                    firstOvf = y_ovf;
                end
                writes++;
            end

            if (done === 1'b1) begin
                dones++;
                doneCyc = r;
            end

            if (resetAt >= 0 && r == resetAt + 1) begin
                checkOutput("rst_ctl", {busy, done, mem_rd, mul_vld, y_we, y_ovf}, 0);
                checkOutput("rst_addr", {x_addr, w_addr, y_addr}, 0);
                checkOutput("rst_data", {mul_a, mul_b, y_data}, 0);
            end
            @(negedge clk);
        end
        start     = 1'b0;
        rst       = 1'b1;
        checkOutput("writes", writes, (resetAt >= 0) ? 0 : nOut);
        checkOutput("done_cnt", dones, (resetAt >= 0) ? 0 : 1);
        if (resetAt < 0) begin
            checkOutput("done_cyc", doneCyc, doneAt);
            checkOutput("rd_cnt", rdCnt, nIn * nOut);
        end
        checkOutput("addr_errs", addrErrs, 0);
        checkOutput("op_errs", opErrs, 0);
        checkOutput("busy_errs", busyErrs, 0);
    endtask

    initial begin
        int          lastW;
        logic [31:0] y0;
        logic        ov0;

        // Reset state while rst is held low.
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_ctl", {busy, done, mem_rd, mul_vld, y_we, y_ovf}, 0);
        checkOutput("reset_addr", {x_addr, w_addr, y_addr}, 0);
        checkOutput("reset_data", {mul_a, mul_b, y_data}, 0);
        rst = 1'b1;

        $display("[TB] basic layer n_in=4 n_out=2");
        // 0.5 * 0.25 in Q15 gives 0.125 in Q31; four terms sum to 0x40000000.
        fillMemory(1'b0);
        applyStimulus(4, 2, -1, -1, lastW, y0, ov0);
        checkOutput("t1_y0", y0, 32'h4000_0000);
        checkOutput("t1_last_w", lastW, 7);

        $display("[TB] empty layers");
        applyStimulus(4, 0, -1, -1, lastW, y0, ov0);
        applyStimulus(0, 3, -1, -1, lastW, y0, ov0);
        checkOutput("n_in0_y0", y0, 32'h0);

        $display("[TB] start and cfg change while busy");
        applyStimulus(4, 2, 5, -1, lastW, y0, ov0);

        $display("[TB] reset mid-run");
        applyStimulus(4, 2, -1, 3, lastW, y0, ov0);
        applyStimulus(4, 2, -1, -1, lastW, y0, ov0);

        $display("[TB] forced large products");
        force_res = 1'b1;
        applyStimulus(4, 1, -1, -1, lastW, y0, ov0);
        force_res = 1'b0;
`ifdef DBN_ACC_SAT_EN
        checkOutput("sat_y", y0, 32'h7FFF_FFFF);
        checkOutput("sat_ovf", ov0, 1'b1);
`else
        checkOutput("wrap_y", y0, 32'h0000_0000);
        checkOutput("wrap_ovf", ov0, 1'b0);
`endif

        $display("[TB] maximum n_in and clamping");
        fillMemory(1'b1);
        applyStimulus(784, 2, -1, -1, lastW, y0, ov0);
        checkOutput("max_last_w", lastW, 1567);
        applyStimulus(1000, 2, -1, -1, lastW, y0, ov0);
        checkOutput("clamp_last_w", lastW, 1567);
        applyStimulus(0, 511, -1, -1, lastW, y0, ov0);

        $display("[TB] random layers");
        for (int t = 0; t < 8; t++) begin
            fillMemory(1'b1);
            applyStimulus(int'($urandom_range(0, 20)), int'($urandom_range(0, 6)),
                          -1, -1, lastW, y0, ov0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
